// File: rtl/cache_arb.sv
// Arbiter sharing one cache front-end port between N_REQ valid/ready requesters.
// Define CACHE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module cache_arb #(
    parameter int N_REQ     = 2,
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int FE_NBYTES = FE_DATA_W / 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               s_valid,
    input  logic [N_REQ*FE_ADDR_W-1:0]     s_addr,
    input  logic [N_REQ*FE_DATA_W-1:0]     s_wdata,
    input  logic [N_REQ*FE_NBYTES-1:0]     s_wstrb,
    output logic [N_REQ-1:0]               s_ready,
    output logic [FE_DATA_W-1:0]           s_rdata,
    output logic                           m_valid,
    output logic [FE_ADDR_W-1:0]           m_addr,
    output logic [FE_DATA_W-1:0]           m_wdata,
    output logic [FE_NBYTES-1:0]           m_wstrb,
    input  logic                           m_ready,
    input  logic [FE_DATA_W-1:0]           m_rdata,
    output logic [$clog2(N_REQ)-1:0]       gnt,
    output logic                           busy
);
    // state | meaning
    // IDLE  | no grant held; pick a winner among s_valid for the next cycle
    // BUSY  | requester gnt owns the cache port until m_ready or it drops s_valid
    localparam int GW = $clog2(N_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;
    logic            done;

`ifndef CACHE_ARB_FIXED_PRIO_EN
    logic [GW-1:0]   ptr;
    logic            found;

    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = GW'((int'(ptr) + k) % N_REQ);
            if (!found && s_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    // Scan downward so the lowest valid index is the last assignment.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = GW'(k);
            if (s_valid[cand]) winner = cand;
        end
    end
`endif

    assign busy    = (state == BUSY);
    assign m_valid = busy && s_valid[gnt];
    assign done    = m_valid && m_ready;

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = '0;
        if (m_valid) begin
            m_addr  = s_addr[gnt*FE_ADDR_W +: FE_ADDR_W];
            m_wdata = s_wdata[gnt*FE_DATA_W +: FE_DATA_W];
            m_wstrb = s_wstrb[gnt*FE_NBYTES +: FE_NBYTES];
        end
        if (done) begin
            s_ready[gnt] = 1'b1;
            s_rdata      = m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|s_valid) begin
                        gnt   <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
`ifndef CACHE_ARB_FIXED_PRIO_EN
                        ptr   <= GW'((int'(gnt) + 1) % N_REQ);
`endif
                    end else if (!s_valid[gnt]) begin
                        // Requester withdrew its request: release without moving the pointer.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arb.sv
// Self-checking bench for cache_arb (N_REQ=2): per-cycle vector table, contention
// sequence, and a scoreboard matching s_ready/s_rdata completions.
module tb_cache_arb;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    s_valid;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*NB-1:0] s_wstrb;
    logic [N-1:0]    s_ready;
    logic [DW-1:0]   s_rdata;
    logic            m_valid;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [NB-1:0]   m_wstrb;
    logic            m_ready;
    logic [DW-1:0]   m_rdata;
    logic [0:0]      gnt;
    logic            busy;

    int checks = 0;
    int errors = 0;

    cache_arb #(.N_REQ(N), .FE_ADDR_W(AW), .FE_DATA_W(DW), .FE_NBYTES(NB)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [1:0]  sv;
        logic        mr;
        logic [31:0] rd;
        logic        e_mv;
        logic        e_busy;
        logic        e_gnt;
        logic [1:0]  e_sr;
        logic [31:0] e_srd;
    } vec_t;

    typedef struct {
        logic [1:0]  sr;
        logic [31:0] srd;
    } done_t;

    vec_t  vecs[$];
    done_t sb[$];

    localparam logic [31:0] ADDR0  = 32'h0000_0100;
    localparam logic [31:0] ADDR1  = 32'h0000_0200;
    localparam logic [31:0] WDATA0 = 32'hAAAA_5555;
    localparam logic [31:0] WDATA1 = 32'h1234_5678;
    localparam logic [3:0]  WSTRB0 = 4'b0000;
    localparam logic [3:0]  WSTRB1 = 4'b0011;

    function automatic vec_t mk(logic rst_n, logic [1:0] sv, logic mr, logic [31:0] rd,
                                logic e_mv, logic e_busy, logic e_gnt,
                                logic [1:0] e_sr, logic [31:0] e_srd);
        vec_t v;
        v.rst_n = rst_n; v.sv = sv; v.mr = mr; v.rd = rd;
        v.e_mv = e_mv; v.e_busy = e_busy; v.e_gnt = e_gnt;
        v.e_sr = e_sr; v.e_srd = e_srd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        done_t d;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        @(negedge clk);
        reset   = v.rst_n;
        s_valid = v.sv;
        m_ready = v.mr;
        m_rdata = v.rd;
        if (v.e_sr != 2'b00) begin
            d.sr = v.e_sr; d.srd = v.e_srd;
            sb.push_back(d);
        end
        #1;
        e_addr  = v.e_mv ? (v.e_gnt ? ADDR1  : ADDR0)  : 32'h0;
        e_wdata = v.e_mv ? (v.e_gnt ? WDATA1 : WDATA0) : 32'h0;
        e_wstrb = v.e_mv ? (v.e_gnt ? WSTRB1 : WSTRB0) : 4'h0;
        check($sformatf("v%0d m_valid", idx), 32'(m_valid), 32'(v.e_mv));
        check($sformatf("v%0d busy", idx),    32'(busy),    32'(v.e_busy));
        check($sformatf("v%0d gnt", idx),     32'(gnt),     32'(v.e_gnt));
        check($sformatf("v%0d s_ready", idx), 32'(s_ready), 32'(v.e_sr));
        check($sformatf("v%0d m_addr", idx),  m_addr,       e_addr);
        check($sformatf("v%0d m_wdata", idx), m_wdata,      e_wdata);
        check($sformatf("v%0d m_wstrb", idx), 32'(m_wstrb), 32'(e_wstrb));
        if (s_ready != 2'b00) begin
            if (sb.size() == 0) begin
                check($sformatf("v%0d unexpected completion", idx), 32'(s_ready), 32'h0);
            end else begin
                d = sb.pop_front();
                check($sformatf("v%0d sb s_ready", idx), 32'(s_ready), 32'(d.sr));
                check($sformatf("v%0d sb s_rdata", idx), s_rdata,      d.srd);
            end
        end else begin
            check($sformatf("v%0d s_rdata idle", idx), s_rdata, 32'h0);
        end
    endtask

    initial begin
        logic eg, pg;
        reset   = 1'b0;
        s_valid = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        s_addr  = {ADDR1, ADDR0};
        s_wdata = {WDATA1, WDATA0};
        s_wstrb = {WSTRB1, WSTRB0};
        repeat (2) @(posedge clk);

        //               rst sv    mr rd            mv bz g  sr     srd
        vecs.push_back(mk(0, 2'b00, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));        // reset state
        vecs.push_back(mk(1, 2'b00, 1, 32'h55,       0, 0, 0, 2'b00, 32'h0));        // spurious m_ready
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));        // single read
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        1, 1, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        1, 1, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b01, 1, 32'hDEADBEEF, 1, 1, 0, 2'b01, 32'hDEADBEEF));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));        // write by req 1
        vecs.push_back(mk(1, 2'b10, 0, 32'h0,        1, 1, 1, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b10, 1, 32'hCAFE0001, 1, 1, 1, 2'b10, 32'hCAFE0001));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 1, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0,        0, 0, 1, 2'b00, 32'h0));        // abandon
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 1, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11,       1, 1, 0, 2'b01, 32'h11));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));        // reset mid-BUSY
        vecs.push_back(mk(0, 2'b10, 0, 32'h0,        1, 1, 1, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b00, 1, 32'h77,       0, 0, 0, 2'b00, 32'h0));        // late m_ready
        vecs.push_back(mk(1, 2'b11, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h99,       1, 1, 0, 2'b01, 32'h99));       // pointer back at 0
        vecs.push_back(mk(1, 2'b00, 0, 32'h0,        0, 0, 0, 2'b00, 32'h0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Contention with both requesters held valid, cache answering after one cycle.
        apply(mk(0, 2'b00, 0, 32'h0, 0, 0, 0, 2'b00, 32'h0), 100);
        pg = 1'b0;
        for (int g = 0; g < 4; g++) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
            eg = 1'b0;
`else
            eg = g[0];
`endif
            apply(mk(1, 2'b11, 0, 32'h0, 0, 0, pg, 2'b00, 32'h0), 200 + 3*g);
            apply(mk(1, 2'b11, 0, 32'h0, 1, 1, eg, 2'b00, 32'h0), 201 + 3*g);
            apply(mk(1, 2'b11, 1, 32'hB000 + 32'(g), 1, 1, eg,
                     eg ? 2'b10 : 2'b01, 32'hB000 + 32'(g)), 202 + 3*g);
            pg = eg;
        end
        apply(mk(1, 2'b00, 0, 32'h0, 0, 0, pg, 2'b00, 32'h0), 300);

        check("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
